pulse_gen_array: RTL

- Parametrised, multi-channel successor to the single-bit edge-to-pulse generator.
- Each channel performs three steps on a raw asynchronous input (push button or switch):
  - synchronises it to clk;
  - debounces it over a programmable stable window;
  - emits a single-cycle, registered pulse on a selectable edge.
- Optional auto-repeat emits periodic pulses while a channel is held high.
- Sits between board I/O pins and the FSM/counter logic of lab designs.

---
 rtl/pulse_gen_array.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pulse_gen_array.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, debounce window,
// single-cycle edge pulse and optional auto-repeat while a channel is held.
module pulse_gen_array #(
  parameter int CH            = 4,
  parameter int DB_CYCLES     = 4,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in_trig,
  output logic [CH-1:0] out_pulse,
  output logic [CH-1:0] level,
  output logic [CH-1:0] repeat_active
);

  localparam int CNT_W   = $clog2(DB_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(RPT_MAX + 1);
  // Auto-repeat only makes sense when presses (rising edges) produce pulses.
  localparam bit RPT_ON  = (REPEAT_EN != 0) && (EDGE_MODE != 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic             s1_reg;
    logic             s2_reg;
    logic             lvl_reg;
    logic             lvl_next;
    logic             lvl_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             rise;
    logic             fall;
    logic             sel;
    logic             rep_tick;
    logic             rpt_act;
    logic             pulse_reg;
    rpt_state_t       state_reg;
    rpt_state_t       state_next;
    logic [RCNT_W-1:0] rcnt_reg;
    logic [RCNT_W-1:0] rcnt_next;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= in_trig[gi];
        s2_reg <= s1_reg;
      end
    end

    // A level change is accepted only after DB_CYCLES consecutive differing samples.
    always_comb begin
      lvl_next = lvl_reg;
      cnt_next = cnt_reg;
      if (s2_reg == lvl_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
        lvl_next = s2_reg;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_reg   <= 1'b0;
        lvl_d_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        lvl_reg   <= lvl_next;
        lvl_d_reg <= lvl_reg;
        cnt_reg   <= cnt_next;
      end
    end

    assign rise = lvl_reg & ~lvl_d_reg;
    assign fall = ~lvl_reg & lvl_d_reg;

    always_comb begin
      sel = 1'b0;
      case (EDGE_MODE)
        0:       sel = rise;
        1:       sel = fall;
        default: sel = rise | fall;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_reg <= ST_IDLE;
        rcnt_reg  <= '0;
      end else begin
        state_reg <= state_next;
        rcnt_reg  <= rcnt_next;
      end
    end

    // Release (lvl low) always wins over a due repeat tick.
    always_comb begin
      state_next = state_reg;
      rcnt_next  = rcnt_reg;
      case (state_reg)
        ST_IDLE: begin
          if (RPT_ON && rise) begin
            state_next = ST_DELAY;
            rcnt_next  = RCNT_W'(1);
          end
        end
        ST_DELAY: begin
          if (!lvl_reg) begin
            state_next = ST_IDLE;
            rcnt_next  = '0;
          end else if (rcnt_reg == RCNT_W'(REPEAT_DELAY)) begin
            state_next = ST_REPEAT;
            rcnt_next  = RCNT_W'(1);
          end else begin
            rcnt_next = rcnt_reg + RCNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!lvl_reg) begin
            state_next = ST_IDLE;
            rcnt_next  = '0;
          end else if (rcnt_reg == RCNT_W'(REPEAT_PERIOD)) begin
            rcnt_next = RCNT_W'(1);
          end else begin
            rcnt_next = rcnt_reg + RCNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end
      endcase
    end

    always_comb begin
      rep_tick = 1'b0;
      rpt_act  = 1'b0;
      case (state_reg)
        ST_DELAY:  rep_tick = lvl_reg && (rcnt_reg == RCNT_W'(REPEAT_DELAY));
        ST_REPEAT: begin
          rep_tick = lvl_reg && (rcnt_reg == RCNT_W'(REPEAT_PERIOD));
          rpt_act  = 1'b1;
        end
        default: begin
          rep_tick = 1'b0;
          rpt_act  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pulse_reg <= 1'b0;
      end else begin
        pulse_reg <= sel | rep_tick;
      end
    end

    assign out_pulse[gi]     = pulse_reg;
    assign level[gi]         = lvl_reg;
    assign repeat_active[gi] = rpt_act;
  end

endmodule
